// File: rtl/ext_unit_pipe.sv
// Pipelined immediate extender (ZERO/SIGN/BRANCH/UPPER) behind a valid/ready
// handshake with a 2-entry skid buffer. Optional transfer counter: EXT_UNIT_CNT_EN.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef EXT_UNIT_CNT_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  typedef enum logic [1:0] {M_ZERO = 2'd0, M_SIGN = 2'd1, M_BRANCH = 2'd2, M_UPPER = 2'd3} mode_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [OUT_W-1:0]   r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic [OUT_W-1:0]   r_sk_data;
  logic [TAG_W-1:0]   r_sk_tag;

  logic [OUT_W-1:0]   w_sext;
  logic [OUT_W-1:0]   w_ext;
  logic               w_acc;
  logic               w_drain;

  assign w_acc   = in_valid & r_in_ready;
  assign w_drain = r_out_valid & out_ready;
  assign w_sext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    w_ext = '0;
    case (mode_t'(in_mode))
      M_ZERO:   w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      M_SIGN:   w_ext = w_sext;
      M_BRANCH: w_ext = w_sext << 2;
      M_UPPER:  w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default:  w_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_sk_data   <= '0;
      r_sk_tag    <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_out_data  <= w_ext;
            r_out_tag   <= in_tag;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_acc && w_drain) begin
            r_out_data <= w_ext;
            r_out_tag  <= in_tag;
          end else if (w_acc) begin
            // Consumer stalled: park the new result and stop accepting.
            r_sk_data  <= w_ext;
            r_sk_tag   <= in_tag;
            r_in_ready <= 1'b0;
            r_state    <= TWO;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            r_out_data <= r_sk_data;
            r_out_tag  <= r_sk_tag;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef EXT_UNIT_CNT_EN
  logic [31:0] r_xfer_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_xfer_count <= '0;
    else if (w_drain)
      r_xfer_count <= r_xfer_count + 32'd1;
  end

  assign xfer_count = r_xfer_count;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed-vector bench for ext_unit_pipe (IN_W=16, OUT_W=32, TAG_W=5).
// Counter checks are compiled in only when EXT_UNIT_CNT_EN is defined.
module tb_ext_unit_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef EXT_UNIT_CNT_EN
  logic [31:0] xfer_count;
`endif

  int unsigned n_total;
  int unsigned n_bad;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef EXT_UNIT_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] mode, input logic [15:0] imm, input logic [4:0] tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  // Accept-and-drain with out_ready high: result visible right after the edge.
  task automatic send1(input string tag, input logic [1:0] mode, input logic [15:0] imm,
                       input logic [4:0] t, input logic [31:0] exp);
    offer(mode, imm, t);
    step();
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"}, out_data, exp);
    chk({tag, ".tag"}, {27'd0, out_tag}, {27'd0, t});
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef EXT_UNIT_CNT_EN
    chk("rst.count", xfer_count, 32'd0);
`endif

    send1("sign_pos", 2'd1, 16'h0017, 5'd3, 32'h0000_0017);
    send1("sign_neg", 2'd1, 16'hFFE9, 5'd4, 32'hFFFF_FFE9);
    send1("zero",     2'd0, 16'hFFE9, 5'd5, 32'h0000_FFE9);
    send1("upper",    2'd3, 16'h1234, 5'd6, 32'h1234_0000);
    send1("br_neg1",  2'd2, 16'hFFFF, 5'd7, 32'hFFFF_FFFC);
    send1("br_3",     2'd2, 16'h0003, 5'd8, 32'h0000_000C);
    send1("br_min",   2'd2, 16'h8000, 5'd9, 32'hFFFE_0000);
    send1("upper_ff", 2'd3, 16'hFFFF, 5'd31, 32'hFFFF_0000);
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 1; i <= 8; i++) begin
      offer(2'd1, 16'(i), 5'(i));
      chk("stream.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("stream.valid", {31'd0, out_valid}, 32'd1);
      chk("stream.data", out_data, 32'(i));
    end
    in_valid = 1'b0;
    step();

    // Stall: A into OR, B into skid, C held off by in_ready=0.
    out_ready = 1'b0;
    offer(2'd1, 16'h00A0, 5'd1);
    step();
    chk("stall.A_rdy", {31'd0, in_ready}, 32'd1);
    chk("stall.A_data", out_data, 32'h0000_00A0);
    offer(2'd0, 16'h00B0, 5'd2);
    step();
    chk("stall.B_rdy", {31'd0, in_ready}, 32'd0);
    chk("stall.B_data", out_data, 32'h0000_00A0);
    offer(2'd3, 16'h00C0, 5'd3);
    step();
    chk("stall.hold_data", out_data, 32'h0000_00A0);
    chk("stall.hold_tag", {27'd0, out_tag}, 32'd1);
    chk("stall.hold_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("order.B_data", out_data, 32'h0000_00B0);
    chk("order.B_tag", {27'd0, out_tag}, 32'd2);
    chk("order.B_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("order.C_data", out_data, 32'h00C0_0000);
    chk("order.C_tag", {27'd0, out_tag}, 32'd3);
    in_valid = 1'b0;
    step();
    chk("order.empty", {31'd0, out_valid}, 32'd0);

    // Reset while TWO, with a new input offered in the same cycle.
    out_ready = 1'b0;
    offer(2'd1, 16'h0011, 5'd1);
    step();
    offer(2'd1, 16'h0022, 5'd2);
    step();
    chk("rst2.pre_rdy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    offer(2'd1, 16'h0033, 5'd3);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2.out_data", out_data, 32'd0);
    out_ready = 1'b1;
    step();
    step();
    chk("rst2.still_empty", {31'd0, out_valid}, 32'd0);

`ifdef EXT_UNIT_CNT_EN
    chk("cnt.after_rst", xfer_count, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      offer(2'd0, 16'(i), 5'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt.five", xfer_count, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("cnt.cleared", xfer_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
